// File: rtl/csu_dac_sequencer.sv
// Current-source-unit array controller: power sequencing, code decode, DWA rotation, testbus select.
// Latency: accepted code drives all unit enables one clock later; pdb/state/atb_ena are registered.
// Backpressure: code_ready is high only in ACTIVE with en asserted; codes are dropped otherwise.
module csu_dac_sequencer #(
  parameter int CODE_W        = 11,
  parameter int N_THERM       = 17,
  parameter int SETTLE_CYCLES = 64,
  parameter int DRAIN_CYCLES  = 4,
  parameter int CODE_MAX      = 1151
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dem_en,
  input  logic              cal_red,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [1:0]        atb_sel,
  output logic              pdb,
  output logic [N_THERM-1:0] therm_en,
  output logic [5:0]        bin_en,
  output logic              bin_red_en,
  output logic [1:0]        atb_ena,
  output logic [1:0]        state,
  output logic              sat
);

  localparam int NW      = CODE_W - 6;
  localparam int PW      = (N_THERM > 1) ? $clog2(N_THERM) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_SETTLE = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_DRAIN  = 2'b11
  } state_t;

  state_t             cur;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      ptr;

  // Decode path signals
  logic [CODE_W-1:0]    code_sat;
  logic                 code_over;
  logic [NW-1:0]        n_units;
  logic [PW-1:0]        ptr_eff;
  logic [N_THERM-1:0]   fill;
  logic [2*N_THERM-1:0] fill_dbl;
  logic [N_THERM-1:0]   therm_nxt;
  logic [PW-1:0]        ptr_nxt;
  int                   ptr_sum;
  logic                 accept;

  assign state      = cur;
  assign code_ready = (cur == ST_ACTIVE) && en;
  assign accept     = code_ready && code_valid;

  // Clamp the code, split into thermometer count and binary remainder, rotate the fill by the pointer
  always_comb begin
    code_over = (code > CODE_W'(CODE_MAX));
    code_sat  = code_over ? CODE_W'(CODE_MAX) : code;
    n_units   = code_sat[CODE_W-1:6];
    ptr_eff   = dem_en ? ptr : '0;
    fill      = '0;
    for (int i = 0; i < N_THERM; i++) begin
      fill[i] = (i < int'(n_units));
    end
    // Rotate left by ptr_eff within N_THERM bits: the bits pushed past the top wrap to the bottom
    fill_dbl  = {{N_THERM{1'b0}}, fill} << ptr_eff;
    therm_nxt = fill_dbl[N_THERM-1:0] | fill_dbl[2*N_THERM-1:N_THERM];
    // Sum never exceeds 2*N_THERM-1, so a single wrap suffices
    ptr_sum   = int'(ptr) + int'(n_units);
    if (ptr_sum >= N_THERM) begin
      ptr_sum = ptr_sum - N_THERM;
    end
    ptr_nxt   = dem_en ? PW'(ptr_sum) : '0;
  end

  // Power sequencing FSM with registered array outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= ST_OFF;
      cnt        <= '0;
      ptr        <= '0;
      pdb        <= 1'b0;
      therm_en   <= '0;
      bin_en     <= '0;
      bin_red_en <= 1'b0;
      atb_ena    <= 2'b00;
      sat        <= 1'b0;
    end else begin
      sat <= 1'b0;
      case (cur)
        ST_OFF: begin
          therm_en   <= '0;
          bin_en     <= '0;
          bin_red_en <= 1'b0;
          if (en) begin
            cur     <= ST_SETTLE;
            pdb     <= 1'b1;
            cnt     <= '0;
            atb_ena <= atb_sel;
          end else begin
            pdb     <= 1'b0;
            atb_ena <= 2'b00;
          end
        end
        ST_SETTLE: begin
          atb_ena <= atb_sel;
          if (!en) begin
            // Abort wins over settle completion
            cur <= ST_DRAIN;
            cnt <= '0;
          end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cur <= ST_ACTIVE;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          atb_ena <= atb_sel;
          if (!en) begin
            cur        <= ST_DRAIN;
            cnt        <= '0;
            therm_en   <= '0;
            bin_en     <= '0;
            bin_red_en <= 1'b0;
          end else if (accept) begin
            therm_en   <= therm_nxt;
            bin_en     <= code_sat[5:0];
            bin_red_en <= cal_red;
            sat        <= code_over;
            ptr        <= ptr_nxt;
          end
        end
        ST_DRAIN: begin
          therm_en   <= '0;
          bin_en     <= '0;
          bin_red_en <= 1'b0;
          if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            // pdb and testbus drop together on the exit edge
            cur     <= ST_OFF;
            cnt     <= '0;
            pdb     <= 1'b0;
            atb_ena <= 2'b00;
          end else begin
            cnt     <= cnt + 1'b1;
            atb_ena <= atb_sel;
          end
        end
        default: begin
          cur <= ST_OFF;
          pdb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csu_dac_sequencer.sv
// Directed bench for csu_dac_sequencer: sequencing, decode, rotation, testbus gating.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_csu_dac_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dem_en;
  logic        cal_red;
  logic [10:0] code;
  logic        code_valid;
  logic        code_ready;
  logic [1:0]  atb_sel;
  logic        pdb;
  logic [16:0] therm_en;
  logic [5:0]  bin_en;
  logic        bin_red_en;
  logic [1:0]  atb_ena;
  logic [1:0]  state;
  logic        sat;

  int total;
  int bad;

  csu_dac_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dem_en     (dem_en),
    .cal_red    (cal_red),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .atb_sel    (atb_sel),
    .pdb        (pdb),
    .therm_en   (therm_en),
    .bin_en     (bin_en),
    .bin_red_en (bin_red_en),
    .atb_ena    (atb_ena),
    .state      (state),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One accepted code: present it for one edge, then withdraw
  task automatic send(input logic [10:0] c, input logic red);
    code       = c;
    cal_red    = red;
    code_valid = 1'b1;
    tick(1);
    code_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; dem_en = 1'b0; cal_red = 1'b0;
    code = '0; code_valid = 1'b0; atb_sel = 2'b11;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Reset / OFF state, testbus held low while powered down
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_pdb", 32'(pdb), 32'h0);
    chk("off_atb", 32'(atb_ena), 32'h0);
    chk("rst_therm", 32'(therm_en), 32'h0);
    chk("off_ready", 32'(code_ready), 32'h0);

    // Power up, testbus follows from the first pdb=1 cycle
    en = 1'b1;
    tick(1);
    chk("up_pdb", 32'(pdb), 32'h1);
    chk("up_state", 32'(state), 32'h1);
    chk("up_atb", 32'(atb_ena), 32'h3);

    // Asynchronous reset with the settle counter at 10
    tick(10);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'h0);
    chk("arst_pdb", 32'(pdb), 32'h0);
    chk("arst_atb", 32'(atb_ena), 32'h0);
    #1 rst = 1'b0;
    tick(1);
    chk("resettle_pdb", 32'(pdb), 32'h1);
    tick(63);
    chk("settle_63", 32'(state), 32'h1);
    tick(1);
    chk("active_64", 32'(state), 32'h2);
    chk("active_ready", 32'(code_ready), 32'h1);

    // Fixed fill decode
    dem_en = 1'b0;
    send(11'd200, 1'b0);
    chk("c200_therm", 32'(therm_en), 32'h00007);
    chk("c200_bin", 32'(bin_en), 32'h08);
    chk("c200_sat", 32'(sat), 32'h0);
    send(11'd2000, 1'b0);
    chk("c2000_therm", 32'(therm_en), 32'h1FFFF);
    chk("c2000_bin", 32'(bin_en), 32'h3F);
    chk("c2000_sat", 32'(sat), 32'h1);
    tick(1);
    chk("sat_pulse", 32'(sat), 32'h0);
    chk("hold_therm", 32'(therm_en), 32'h1FFFF);

    // Redundant LSB with zero code
    send(11'd0, 1'b1);
    chk("red_therm", 32'(therm_en), 32'h0);
    chk("red_bin", 32'(bin_en), 32'h0);
    chk("red_en", 32'(bin_red_en), 32'h1);

    // Rotation across the thermometer units
    dem_en = 1'b1;
    send(11'd640, 1'b0);
    chk("dwa1", 32'(therm_en), 32'h003FF);
    chk("dwa1_red", 32'(bin_red_en), 32'h0);
    send(11'd640, 1'b0);
    chk("dwa2", 32'(therm_en), 32'h1FC07);
    send(11'd384, 1'b0);
    chk("dwa3", 32'(therm_en), 32'h001F8);
    // Pointer should now be 9: a single unit lands on bit 9
    send(11'd65, 1'b1);
    chk("dwa_ptr9", 32'(therm_en), 32'h00200);
    chk("dwa_ptr9_bin", 32'(bin_en), 32'h01);

    // en falls with a code offered: not accepted, enables cleared, then drain
    en = 1'b0;
    code = 11'd200;
    code_valid = 1'b1;
    #1;
    chk("fall_ready", 32'(code_ready), 32'h0);
    tick(1);
    code_valid = 1'b0;
    chk("drain_state", 32'(state), 32'h3);
    chk("drain_therm", 32'(therm_en), 32'h0);
    chk("drain_bin", 32'(bin_en), 32'h0);
    chk("drain_red", 32'(bin_red_en), 32'h0);
    chk("drain_pdb", 32'(pdb), 32'h1);
    tick(2);
    en = 1'b1;  // must be ignored until OFF
    tick(1);
    chk("drain_hold", 32'(state), 32'h3);
    chk("drain_atb", 32'(atb_ena), 32'h3);
    tick(1);
    chk("off_state", 32'(state), 32'h0);
    chk("off_pdb", 32'(pdb), 32'h0);
    chk("off_atb2", 32'(atb_ena), 32'h0);
    tick(1);
    chk("reentry_state", 32'(state), 32'h1);
    chk("reentry_atb", 32'(atb_ena), 32'h3);

    // Abort during settle goes to drain
    en = 1'b0;
    tick(1);
    chk("abort_state", 32'(state), 32'h3);
    chk("abort_therm", 32'(therm_en), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csu_dac_sequencer.md
Name: csu_dac_sequencer

Overview:
Digital controller for the current-source unit array: 17 thermometer units (64 LSB each), 6 binary units (32..1 LSB) and 1 redundant LSB unit.
- Sequences power-up and power-down of the array via pdb, with a bias-settle wait.
- Decodes an 11-bit DAC code into per-unit enables.
- Applies optional data-weighted-averaging rotation across the thermometer units to spread unit mismatch.
- Registers the analog-testbus selection.

Parameters:
- CODE_W, 11, code width.
- N_THERM, 17, thermometer unit count.
- SETTLE_CYCLES, 64, cycles from pdb rise to ACTIVE (≥1).
- DRAIN_CYCLES, 4, cycles from enables-off to pdb fall (≥1).
- CODE_MAX, 1151, full scale = N_THERM*64+63.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  array enable request.
- dem_en  in  1  1 = rotate thermometer selection (DWA); 0 = fixed low-index fill.
- cal_red  in  1  redundant-LSB enable request, sampled with each accepted code.
- code  in  CODE_W  requested output code, in LSB units.
- code_valid  in  1  code offered.
- code_ready  out  1  code accepted when code_valid&code_ready.
- atb_sel  in  2  testbus selection request.
- pdb  out  1  array power-down negate.
- therm_en  out  N_THERM  thermometer unit enables.
- bin_en  out  6  binary unit enables; bit i = 2^i LSB.
- bin_red_en  out  1  redundant LSB enable.
- atb_ena  out  2  testbus selection to array.
- state  out  2  OFF=00, SETTLE=01, ACTIVE=10, DRAIN=11.
- sat  out  1  one-cycle pulse: last accepted code exceeded CODE_MAX.

Behaviour:
Reset (async, any time including mid-sequence):
- state=OFF.
- pdb, therm_en, bin_en, bin_red_en, atb_ena, sat all 0.
- Rotation pointer=0, counter=0.

FSM:
- OFF: en=1 → SETTLE; pdb<=1; counter<=0.
- SETTLE: counter increments each cycle.
  - en=0 → DRAIN (counter<=0). This takes priority.
  - counter==SETTLE_CYCLES-1 → ACTIVE.
- ACTIVE: en=0 → DRAIN; counter<=0; therm_en, bin_en, bin_red_en <=0 at the same edge.
- DRAIN: counter increments; counter==DRAIN_CYCLES-1 → OFF with pdb<=0.
  - en=1 during DRAIN is ignored until OFF is reached. Re-entry to SETTLE takes ≥1 cycle in OFF.
- pdb=1 in SETTLE, ACTIVE, DRAIN; 0 in OFF.

Handshake:
- code_ready = (state==ACTIVE) && en. This is combinational, so no code is accepted in the cycle en falls.
- Accepted code updates enables at the same clock edge: one-cycle latency, with all enables changing together.
- Outputs hold between accepts.
- Enables are never 1 outside ACTIVE.

Decode:
- c = min(code, CODE_MAX). sat<=1 for one cycle if code>CODE_MAX.
- n = c>>6 (0..17); bin_en = c[5:0]; bin_red_en = cal_red.
- therm_en: exactly n bits set, at indices p, p+1, … p+n-1, each mod N_THERM, where p is the current pointer.
- dem_en=1: pointer <= (p+n) mod N_THERM after each accept.
- dem_en=0: indices 0..n-1 are used (p treated as 0) and pointer <= 0.
- n=17 sets all bits regardless of p; the pointer is then unchanged (mod 17).
- The pointer persists across DRAIN/OFF and is cleared only by rst.

Testbus:
- atb_ena <= atb_sel each cycle while pdb=1.
- atb_ena <= 00 while pdb=0, including the cycle pdb falls.

Test Plan:
- rst pulse asynchronously mid-SETTLE (counter=10) → all outputs 0 immediately, state=OFF; after release, en=1 → pdb=1 next edge, state=ACTIVE exactly SETTLE_CYCLES edges later.
- ACTIVE, dem_en=0, code=200 → next cycle therm_en=17'h00007, bin_en=6'b001000; code=2000 → therm_en=17'h1FFFF, bin_en=6'h3F, sat=1 for one cycle.
- dem_en=1, pointer 0, codes 640, 640, 384 (n=10, 10, 6) → therm_en bits 0..9; then bits 10..16 and 0..2; then bits 3..8; final pointer=9.
- ACTIVE, en falls in the same cycle code_valid=1 → code not accepted, enables cleared next edge, pdb=0 after DRAIN_CYCLES, atb_ena=00 in that same cycle.
- atb_sel=2'b11 in OFF → atb_ena stays 00; after en=1 → atb_ena=11 from the first cycle with pdb=1.
- cal_red=1 with code=0 → therm_en=0, bin_en=0, bin_red_en=1.
